// File: rtl/fifo_umbral_pkg.sv
// Shared sizing constants and threshold reset values for the thresholded FIFO and its controller.
package fifo_umbral_pkg;

    localparam int unsigned DATA_WIDTH      = 6;
    localparam int unsigned ADDR_WIDTH      = 3;
    localparam int unsigned U_WIDTH         = 4;
    localparam int unsigned DEPTH           = 2 ** ADDR_WIDTH;
    localparam int unsigned UMBRAL_ALTO_RST = DEPTH - 1;
    localparam int unsigned UMBRAL_BAJO_RST = 1;

    // Almost-full reset value for an arbitrary address width: one below full.
    function automatic int unsigned umbral_alto_rst(input int unsigned addr_width);
        return (2 ** addr_width) - 1;
    endfunction

endpackage

// File: rtl/fifo_umbral_if.sv
// Access, threshold and status bundle between the FIFO and its controller.
interface fifo_umbral_if #(
    parameter int unsigned DATA_WIDTH = fifo_umbral_pkg::DATA_WIDTH,
    parameter int unsigned U_WIDTH    = fifo_umbral_pkg::U_WIDTH
);

    logic                  init;
    logic [U_WIDTH-1:0]    umbral_alto;
    logic [U_WIDTH-1:0]    umbral_bajo;
    logic                  wr_enable;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  fifo_error;
    logic [U_WIDTH-1:0]    count;

    modport master (
        output init, umbral_alto, umbral_bajo, wr_enable, data_in, rd_enable,
        input  data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty,
        input  fifo_error, count
    );

    modport slave (
        input  init, umbral_alto, umbral_bajo, wr_enable, data_in, rd_enable,
        output data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty,
        output fifo_error, count
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register file: one write port, one registered read port.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = fifo_umbral_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_umbral_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately not reset; pointers guarantee stale words are never read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a read and write to the same slot returns the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with latched almost-full/almost-empty thresholds and a sticky error flag.
module fifo_umbral #(
    parameter int unsigned DATA_WIDTH = fifo_umbral_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_umbral_pkg::ADDR_WIDTH,
    parameter int unsigned U_WIDTH    = fifo_umbral_pkg::U_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  fifo_if
);

    import fifo_umbral_pkg::*;

    localparam logic [U_WIDTH-1:0] LP_DEPTH    = U_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [U_WIDTH-1:0] LP_ALTO_RST = U_WIDTH'(umbral_alto_rst(ADDR_WIDTH));
    localparam logic [U_WIDTH-1:0] LP_BAJO_RST = U_WIDTH'(UMBRAL_BAJO_RST);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [U_WIDTH-1:0]    r_count;
    logic [U_WIDTH-1:0]    r_umbral_alto;
    logic [U_WIDTH-1:0]    r_umbral_bajo;
    logic                  r_valid;
    logic                  r_error;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_overflow;
    logic w_underflow;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LP_DEPTH);
    assign w_rd_acc    = fifo_if.rd_enable && !w_empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_wr_acc    = fifo_if.wr_enable && (!w_full || w_rd_acc);
    assign w_overflow  = fifo_if.wr_enable && w_full && !w_rd_acc;
    assign w_underflow = fifo_if.rd_enable && w_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_error       <= 1'b0;
            r_umbral_alto <= LP_ALTO_RST;
            r_umbral_bajo <= LP_BAJO_RST;
        end else begin
            r_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + U_WIDTH'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - U_WIDTH'(1);
            end
            // A fault in the same cycle as init still sets the flag.
            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end else if (fifo_if.init) begin
                r_error <= 1'b0;
            end
            if (fifo_if.init) begin
                r_umbral_alto <= fifo_if.umbral_alto;
                r_umbral_bajo <= fifo_if.umbral_bajo;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_mem (
        .clk     (clk),
        .reset   (reset),
        .i_wr_en (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (fifo_if.data_in),
        .i_rd_en (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (fifo_if.data_out)
    );

    // Out-of-range thresholds fall out of the plain compares: count never exceeds DEPTH.
    assign fifo_if.valid_out    = r_valid;
    assign fifo_if.fifo_error   = r_error;
    assign fifo_if.count        = r_count;
    assign fifo_if.fifo_empty   = w_empty;
    assign fifo_if.fifo_full    = w_full;
    assign fifo_if.almost_full  = (r_count >= r_umbral_alto);
    assign fifo_if.almost_empty = (r_count <= r_umbral_bajo);

endmodule

// File: tb/tb_fifo_umbral.sv
// Randomised and directed bench for fifo_umbral against a queue-based reference model.
module tb_fifo_umbral;

    localparam int unsigned DW  = 6;
    localparam int unsigned AW  = 3;
    localparam int unsigned UW  = 4;
    localparam int unsigned DEP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fifo_umbral_if #(.DATA_WIDTH(DW), .U_WIDTH(UW)) bus ();

    fifo_umbral #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .U_WIDTH    (UW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .fifo_if (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_data  = '0;
    bit            m_valid = 1'b0;
    bit            m_err   = 1'b0;
    int            m_alto  = DEP - 1;
    int            m_bajo  = 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, in terms of queue occupancy.
    task automatic model_step();
        bit rd_ok, wr_ok, bad;
        int n;
        if (!reset) begin
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_alto  = DEP - 1;
            m_bajo  = 1;
            return;
        end
        n     = m_q.size();
        rd_ok = bus.rd_enable && (n > 0);
        wr_ok = bus.wr_enable && ((n < DEP) || rd_ok);
        bad   = (bus.wr_enable && (n == DEP) && !rd_ok) || (bus.rd_enable && (n == 0));
        m_valid = rd_ok;
        if (rd_ok) m_data = m_q.pop_front();
        if (wr_ok) m_q.push_back(bus.data_in);
        if (bad) m_err = 1'b1;
        else if (bus.init) m_err = 1'b0;
        if (bus.init) begin
            m_alto = int'(bus.umbral_alto);
            m_bajo = int'(bus.umbral_bajo);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("count",        int'(bus.count),        n);
        check("fifo_empty",   int'(bus.fifo_empty),   int'(n == 0));
        check("fifo_full",    int'(bus.fifo_full),    int'(n == DEP));
        check("almost_full",  int'(bus.almost_full),  int'(n >= m_alto));
        check("almost_empty", int'(bus.almost_empty), int'(n <= m_bajo));
        check("fifo_error",   int'(bus.fifo_error),   int'(m_err));
        check("valid_out",    int'(bus.valid_out),    int'(m_valid));
        check("data_out",     int'(bus.data_out),     int'(m_data));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit wr, input bit rd, input logic [DW-1:0] d, input bit ini);
        bus.wr_enable = wr;
        bus.rd_enable = rd;
        bus.data_in   = d;
        bus.init      = ini;
        cycle();
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        bus.init      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEP && m_q.size() > 0; i++) drive(1'b0, 1'b1, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < DEP && m_q.size() < DEP; i++) drive(1'b1, 1'b0, base + DW'(i), 1'b0);
    endtask

    initial begin
        bus.init        = 1'b0;
        bus.umbral_alto = 4'd7;
        bus.umbral_bajo = 4'd1;
        bus.wr_enable   = 1'b0;
        bus.rd_enable   = 1'b0;
        bus.data_in     = '0;

        // Reset state
        reset = 1'b0;
        drive(1'b1, 1'b0, 6'h2A, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b0);
        check("rst_empty", int'(bus.fifo_empty), 1);
        check("rst_ae",    int'(bus.almost_empty), 1);
        check("rst_af",    int'(bus.almost_full), 0);
        reset = 1'b1;

        // Fill then drain
        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
        check("fill_full",  int'(bus.fifo_full), 1);
        check("fill_count", int'(bus.count), 8);
        drive(1'b0, 1'b1, '0, 1'b0);
        check("drain_first", int'(bus.data_out), 1);
        drain();

        // Overflow then clear with init
        fill(6'h10);
        drive(1'b1, 1'b0, 6'h3F, 1'b0);
        check("ovf_err",   int'(bus.fifo_error), 1);
        check("ovf_count", int'(bus.count), 8);
        bus.umbral_alto = 4'd7;
        bus.umbral_bajo = 4'd1;
        drive(1'b0, 1'b0, '0, 1'b1);
        check("ovf_clear", int'(bus.fifo_error), 0);
        drain();

        // Underflow with simultaneous write
        drive(1'b1, 1'b1, 6'h15, 1'b0);
        check("udf_err",   int'(bus.fifo_error), 1);
        check("udf_valid", int'(bus.valid_out), 0);
        check("udf_count", int'(bus.count), 1);
        drive(1'b0, 1'b1, '0, 1'b0);
        check("udf_data", int'(bus.data_out), 6'h15);

        // Thresholds 5/2, also clears the error
        bus.umbral_alto = 4'd5;
        bus.umbral_bajo = 4'd2;
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, DW'(6'h20 + i), 1'b0);
            if (i == 2) check("thr_ae_off", int'(bus.almost_empty), 0);
            if (i == 3) check("thr_af_4",   int'(bus.almost_full), 0);
            if (i == 4) check("thr_af_on",  int'(bus.almost_full), 1);
        end

        // Full with simultaneous access, then mid-operation reset
        fill(6'h30);
        drive(1'b1, 1'b1, 6'h2B, 1'b0);
        check("full_rw_count", int'(bus.count), 8);
        check("full_rw_err",   int'(bus.fifo_error), 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, '0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 1'b1, 6'h01, 1'b1);
        check("mid_rst_count", int'(bus.count), 0);
        reset = 1'b1;

        // Randomised traffic with occasional init and rare reset
        for (int i = 0; i < 3000; i++) begin
            bus.umbral_alto = 4'($urandom_range(0, 15));
            bus.umbral_bajo = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 199) != 0);
            drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                  DW'($urandom), ($urandom_range(0, 19) == 0));
            reset = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
